// File: rtl/cu_config_loader_if.sv
// cu_config_loader_if: config word stream, field outputs and run handshake of the loader
interface cu_config_loader_if #(parameter int W = 7);
   logic          io_in_valid;
   logic          io_in_ready;
   logic [W-1:0]  io_in_data;
   logic          io_config_enable;
   logic          io_rmux0;
   logic          io_rmux1;
   logic          io_opA_isLocal;
   logic          io_opB_isLocal;
   logic [W-1:0]  io_opcode;
   logic [W-1:0]  io_opA_local;
   logic [W-1:0]  io_opA_remote;
   logic [W-1:0]  io_opB_local;
   logic [W-1:0]  io_opB_remote;
   logic [W-1:0]  io_result;
   logic          io_enable;
   logic          io_done;
   logic          io_finished;
   logic [15:0]   io_cycles;
   modport master (
      output io_in_valid, io_in_data, io_done,
      input  io_in_ready, io_config_enable, io_rmux0, io_rmux1, io_opA_isLocal, io_opB_isLocal,
             io_opcode, io_opA_local, io_opA_remote, io_opB_local, io_opB_remote, io_result,
             io_enable, io_finished, io_cycles
   );
   modport slave (
      input  io_in_valid, io_in_data, io_done,
      output io_in_ready, io_config_enable, io_rmux0, io_rmux1, io_opA_isLocal, io_opB_isLocal,
             io_opcode, io_opA_local, io_opA_remote, io_opB_local, io_opB_remote, io_result,
             io_enable, io_finished, io_cycles
   );
endinterface

// File: rtl/cu_config_loader.sv
// cu_config_loader: loads a 7-word config, commits it, runs the compute unit and times the run
module cu_config_loader #(parameter int W = 7) (
   input  logic              clk,
   input  logic              reset,
   cu_config_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, COMMIT, RUN, FINISH} state_t;
   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [3:0]    flags_sh_q, flags_q;
   logic [W-1:0]  sh_q  [1:6];
   logic [W-1:0]  out_q [1:6];
   logic [15:0]   cnt_q, cycles_q;
   logic          accept;
   assign bus.io_in_ready      = (state_q == IDLE) || (state_q == LOAD);
   assign accept               = bus.io_in_valid && bus.io_in_ready;
   assign bus.io_config_enable = state_q == COMMIT;
   assign bus.io_enable        = state_q == RUN;
   assign bus.io_finished      = state_q == FINISH;
   assign bus.io_cycles        = cycles_q;
   assign bus.io_rmux0         = flags_q[0];
   assign bus.io_rmux1         = flags_q[1];
   assign bus.io_opA_isLocal   = flags_q[2];
   assign bus.io_opB_isLocal   = flags_q[3];
   assign bus.io_opcode        = out_q[1];
   assign bus.io_opA_local     = out_q[2];
   assign bus.io_opA_remote    = out_q[3];
   assign bus.io_opB_local     = out_q[4];
   assign bus.io_opB_remote    = out_q[5];
   assign bus.io_result        = out_q[6];
   // state and word index registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end
   // sequencing: word acceptance, commit strobe, run until io_done, finish pulse
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: if (accept) begin
            state_d = LOAD;
            idx_d   = 3'd1;
         end
         LOAD: if (accept) begin
            idx_d   = idx_q + 3'd1;
            state_d = (idx_q == 3'd6) ? COMMIT : LOAD;
         end
         COMMIT: state_d = RUN;
         RUN:    state_d = bus.io_done ? FINISH : RUN;
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // shadow assembly, commit copy to outputs, saturating run counter and its latch
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_sh_q <= '0;
         flags_q    <= '0;
         cnt_q      <= '0;
         cycles_q   <= '0;
         for (int i = 1; i <= 6; i++) begin
            sh_q[i]  <= '0;
            out_q[i] <= '0;
         end
      end else begin
         if (accept && state_q == IDLE) flags_sh_q <= bus.io_in_data[3:0];
         if (accept && state_q == LOAD) sh_q[idx_q] <= bus.io_in_data;
         if (state_q == COMMIT) begin
            flags_q <= flags_sh_q;
            cnt_q   <= '0;
            for (int i = 1; i <= 6; i++) out_q[i] <= sh_q[i];
         end
         if (state_q == RUN && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         if (state_q == FINISH) cycles_q <= cnt_q;
      end
   end
endmodule

// File: tb/tb_cu_config_loader.sv
// tb_cu_config_loader: directed and randomized loads/runs checked against a field-level model
module tb_cu_config_loader;
   localparam int W = 7;
   typedef logic [W-1:0] word_t;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [3:0] exp_flags;
   word_t      exp_f [1:6];
   word_t      wv [7];
   word_t      nv [7];
   cu_config_loader_if #(.W(W)) bus ();
   cu_config_loader #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_cfg(input string tag);
      chk({tag, ".rmux0"}, bus.io_rmux0, exp_flags[0]);
      chk({tag, ".rmux1"}, bus.io_rmux1, exp_flags[1]);
      chk({tag, ".opA_isLocal"}, bus.io_opA_isLocal, exp_flags[2]);
      chk({tag, ".opB_isLocal"}, bus.io_opB_isLocal, exp_flags[3]);
      chk({tag, ".opcode"}, bus.io_opcode, exp_f[1]);
      chk({tag, ".opA_local"}, bus.io_opA_local, exp_f[2]);
      chk({tag, ".opA_remote"}, bus.io_opA_remote, exp_f[3]);
      chk({tag, ".opB_local"}, bus.io_opB_local, exp_f[4]);
      chk({tag, ".opB_remote"}, bus.io_opB_remote, exp_f[5]);
      chk({tag, ".result"}, bus.io_result, exp_f[6]);
   endtask
   task automatic clear_model();
      exp_flags = '0;
      for (int i = 1; i <= 6; i++) exp_f[i] = '0;
   endtask
   task automatic rand_words(output word_t w[7]);
      for (int i = 0; i < 7; i++) w[i] = word_t'($urandom);
   endtask
   task automatic send(input word_t w[7], input int gap, input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0)
            for (int g = 0; g < gap; g++) begin
               bus.io_in_valid = 1'b0;
               tick();
               chk("gap.ready", bus.io_in_ready, 1);
               chk("gap.cfg_en", bus.io_config_enable, 0);
               chk_cfg("gap");
            end
         bus.io_in_valid = 1'b1;
         bus.io_in_data  = w[i];
         for (int t = 0; t < 40 && !bus.io_in_ready; t++) tick();
         chk("send.ready", bus.io_in_ready, 1);
         tick();
      end
      bus.io_in_valid = 1'b0;
   endtask
   task automatic commit(input word_t w[7]);
      chk("commit.cfg_en", bus.io_config_enable, 1);
      chk("commit.enable", bus.io_enable, 0);
      chk("commit.ready", bus.io_in_ready, 0);
      chk_cfg("commit.hold");
      exp_flags = w[0][3:0];
      for (int i = 1; i <= 6; i++) exp_f[i] = w[i];
      tick();
      chk("run1.cfg_en", bus.io_config_enable, 0);
      chk("run1.enable", bus.io_enable, 1);
      chk_cfg("run1");
   endtask
   task automatic run(input int k);
      for (int c = 1; c <= k; c++) begin
         bus.io_done = (c == k);
         chk("run.enable", bus.io_enable, 1);
         chk("run.ready", bus.io_in_ready, 0);
         chk("run.finished", bus.io_finished, 0);
         tick();
      end
      bus.io_done = 1'b0;
      chk("finish.pulse", bus.io_finished, 1);
      chk("finish.enable", bus.io_enable, 0);
      chk("finish.ready", bus.io_in_ready, 0);
      tick();
      chk("idle.finished", bus.io_finished, 0);
      chk("idle.enable", bus.io_enable, 0);
      chk("idle.ready", bus.io_in_ready, 1);
      chk("idle.cycles", bus.io_cycles, (k < 65535) ? k : 65535);
      chk_cfg("idle");
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, ".ready"}, bus.io_in_ready, 1);
      chk({tag, ".cfg_en"}, bus.io_config_enable, 0);
      chk({tag, ".enable"}, bus.io_enable, 0);
      chk({tag, ".finished"}, bus.io_finished, 0);
      chk({tag, ".cycles"}, bus.io_cycles, 0);
      chk_cfg(tag);
   endtask
   initial begin
      reset = 1'b1;
      bus.io_in_valid = 1'b0;
      bus.io_in_data  = '0;
      bus.io_done     = 1'b0;
      clear_model();
      tick();
      tick();
      reset = 1'b0;
      chk_zero("reset");
      wv = '{7'h03, 7'h05, 7'h11, 7'h22, 7'h33, 7'h44, 7'h01};
      send(wv, 0, 7);
      commit(wv);
      chk("b2b.opcode", bus.io_opcode, 5);
      chk("b2b.opB_remote", bus.io_opB_remote, 7'h44);
      run(10);
      rand_words(wv);
      send(wv, 3, 7);
      commit(wv);
      run(int'($urandom_range(1, 12)));
      rand_words(wv);
      bus.io_done = 1'b1;
      send(wv, 1, 7);
      commit(wv);
      run(1);
      rand_words(wv);
      send(wv, 0, 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_model();
      chk_zero("abort");
      rand_words(wv);
      send(wv, 0, 7);
      commit(wv);
      rand_words(nv);
      bus.io_in_valid = 1'b1;
      bus.io_in_data  = nv[0];
      run(int'($urandom_range(2, 8)));
      send(nv, 0, 7);
      commit(nv);
      run(3);
      for (int r = 0; r < 4; r++) begin
         rand_words(wv);
         send(wv, int'($urandom_range(0, 2)), 7);
         commit(wv);
         run(int'($urandom_range(1, 15)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cu_config_loader.md
CU_CONFIG_LOADER -- requirements
Module: cu_config_loader

Interface
REQ-001 SHALL have parameter W, default 7, the width of each config field and each input word.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port io_in_valid  input  1  config word offered.
REQ-005 SHALL have port io_in_ready  output  1  loader accepts the word this cycle.
REQ-006 SHALL have port io_in_data  input  W  config word.
REQ-007 SHALL have port io_config_enable  output  1  one-cycle commit strobe to the compute unit.
REQ-008 SHALL have port io_rmux0, io_rmux1, io_opA_isLocal, io_opB_isLocal  output  1 each  config flag fields.
REQ-009 SHALL have port io_opcode, io_opA_local, io_opA_remote, io_opB_local, io_opB_remote, io_result  output  W each  config fields.
REQ-010 SHALL have port io_enable  output  1  run enable to the compute unit.
REQ-011 SHALL have port io_done  input  1  compute unit completion.
REQ-012 SHALL have port io_finished  output  1  one-cycle pulse when the run ends.
REQ-013 SHALL have port io_cycles  output  16  run length of the last completed run.

Function
REQ-014 SHALL accept a word only when io_in_valid and io_in_ready are both high; io_in_ready SHALL be high only in IDLE and LOAD.
REQ-015 SHALL map seven words in order: w0[0]=rmux0, w0[1]=rmux1, w0[2]=opA_isLocal, w0[3]=opB_isLocal, w0[W-1:4] ignored; w1=opcode; w2=opA_local; w3=opA_remote; w4=opB_local; w5=opB_remote; w6=result.
REQ-016 SHALL implement states IDLE, LOAD, COMMIT, RUN, FINISH.
REQ-017 SHALL move IDLE->LOAD on acceptance of w0, with word index = 1.
REQ-018 SHALL, in LOAD, store each accepted word into the field given by the word index, then increment the index; acceptance of w6 SHALL go to COMMIT.
REQ-019 SHALL, in LOAD with io_in_valid low, hold the state and index with no timeout.
REQ-020 SHALL assemble fields into shadow registers; the io_* field outputs SHALL update from the shadow registers only in the cycle io_config_enable is high, and SHALL otherwise hold their previous config.
REQ-021 SHALL assert io_config_enable for exactly one cycle in COMMIT, then go to RUN.
REQ-022 SHALL hold io_enable high in every RUN cycle and low in all other states.
REQ-023 SHALL increment a 16-bit run counter each RUN cycle, starting from 0 and saturating at 0xFFFF.
REQ-024 SHALL go RUN->FINISH in the cycle io_done is sampled high in RUN; that cycle SHALL be counted.
REQ-025 SHALL ignore io_done outside RUN.
REQ-026 SHALL, in FINISH, pulse io_finished for one cycle, latch the run counter into io_cycles, and return to IDLE.
REQ-027 SHALL, on io_done high in the first RUN cycle, report io_cycles = 1.
REQ-028 SHALL accept a new w0 in the cycle after FINISH at the earliest, since IDLE is a distinct cycle.

Reset
REQ-029 SHALL, on reset high at any clock edge including mid-LOAD or mid-RUN, enter IDLE, clear the word index, the shadow registers, all field outputs and io_cycles to 0, and drive io_config_enable, io_enable and io_finished to 0.
REQ-030 SHALL discard any partially loaded configuration on reset, with no commit.
REQ-031 SHALL drive io_in_ready to 1 in the first cycle after reset deasserts.

Verification
REQ-032 Bench SHALL cover: words 0x03,0x05,0x11,0x22,0x33,0x44,0x01 back-to-back -> io_config_enable pulses in the cycle after w6; then rmux0=1, rmux1=1, opcode=5, opA_local=0x11, opA_remote=0x22, opB_local=0x33, opB_remote=0x44, result=1; io_enable high the next cycle.
REQ-033 Bench SHALL cover: valid gaps of 3 cycles between words -> fields unchanged and io_config_enable low until w6 is accepted; io_in_ready held high throughout.
REQ-034 Bench SHALL cover: io_done raised after 9 RUN cycles -> io_finished pulses once, io_cycles=10, io_enable low, io_in_ready high in the following cycle.
REQ-035 Bench SHALL cover: io_done held high across COMMIT -> ignored until RUN; io_cycles=1.
REQ-036 Bench SHALL cover: reset asserted after w3 -> io_in_ready=1 and all outputs 0; a fresh 7-word load commits with no residue from the aborted load.
REQ-037 Bench SHALL cover: io_in_valid offered during RUN -> io_in_ready=0, word not consumed, and that word accepted as w0 after FINISH.
